// File: rtl/bp_queue.sv
// Branch-prediction queue: pairs each fetch PC with the predictor result that
// arrives one cycle later, and holds the pair in order for decode. Optional macro: BPQ_BYPASS_EN.
module bp_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_bp_req,
    input  logic [29:0] fetch_bp_addr,
    input  logic [15:0] brpred_bptag,
    input  logic        brpred_bptaken,
    input  logic        rob_flush,
    output logic        bpq_full,
    output logic        bpq_valid,
    output logic [29:0] bpq_addr,
    output logic [15:0] bpq_bptag,
    output logic        bpq_bptaken,
    input  logic        dec_bpq_ready
);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             pending;
    logic [29:0]      lat_addr;

    logic [29:0] mem_addr  [DEPTH];
    logic [15:0] mem_tag   [DEPTH];
    logic        mem_taken [DEPTH];

    logic [PTR_W+1:0] occupancy;
    logic             accept;
    logic             capture;
    logic             stored_valid;
    logic             do_enq;
    logic             do_deq;

    // The pending request reserves a slot so fetch is throttled before the capture lands.
    always_comb begin
        occupancy    = {1'b0, count} + (PTR_W+2)'(pending);
        bpq_full     = (occupancy >= (PTR_W+2)'(DEPTH));
        accept       = fetch_bp_req & ~bpq_full & ~rob_flush;
        capture      = pending & ~rob_flush;
        stored_valid = (count != '0);
    end

`ifdef BPQ_BYPASS_EN
    logic bypass;

    // An empty queue forwards the capture straight to decode; a consumed bypass is never written.
    always_comb begin
        bypass      = capture & ~stored_valid;
        bpq_valid   = stored_valid | bypass;
        bpq_addr    = mem_addr[head];
        bpq_bptag   = mem_tag[head];
        bpq_bptaken = mem_taken[head];
        if (bypass) begin
            bpq_addr    = lat_addr;
            bpq_bptag   = brpred_bptag;
            bpq_bptaken = brpred_bptaken;
        end
        do_deq = stored_valid & dec_bpq_ready & ~rob_flush;
        do_enq = capture & ~(bypass & dec_bpq_ready);
    end
`else
    always_comb begin
        bpq_valid   = stored_valid;
        bpq_addr    = mem_addr[head];
        bpq_bptag   = mem_tag[head];
        bpq_bptaken = mem_taken[head];
        do_deq      = stored_valid & dec_bpq_ready & ~rob_flush;
        do_enq      = capture;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else if (rob_flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (do_enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_deq) begin
                head <= head + PTR_W'(1);
            end
            count   <= count + (PTR_W+1)'(do_enq) - (PTR_W+1)'(do_deq);
            pending <= accept;
        end
    end

    // Payload storage and the request address are left unreset; valid/count qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr <= fetch_bp_addr;
        end
        if (do_enq) begin
            mem_addr[tail]  <= lat_addr;
            mem_tag[tail]   <= brpred_bptag;
            mem_taken[tail] <= brpred_bptaken;
        end
    end

endmodule

// File: tb/tb_bp_queue.sv
// Scoreboard bench for bp_queue: stimulus predicts entries into a queue,
// a negedge monitor pops and compares whenever decode consumes the head.
module tb_bp_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_bp_req;
    logic [29:0] fetch_bp_addr;
    logic [15:0] brpred_bptag;
    logic        brpred_bptaken;
    logic        rob_flush;
    logic        bpq_full;
    logic        bpq_valid;
    logic [29:0] bpq_addr;
    logic [15:0] bpq_bptag;
    logic        bpq_bptaken;
    logic        dec_bpq_ready;

    always #5 clk = ~clk;

    bp_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_bp_req   (fetch_bp_req),
        .fetch_bp_addr  (fetch_bp_addr),
        .brpred_bptag   (brpred_bptag),
        .brpred_bptaken (brpred_bptaken),
        .rob_flush      (rob_flush),
        .bpq_full       (bpq_full),
        .bpq_valid      (bpq_valid),
        .bpq_addr       (bpq_addr),
        .bpq_bptag      (bpq_bptag),
        .bpq_bptaken    (bpq_bptaken),
        .dec_bpq_ready  (dec_bpq_ready)
    );

    typedef struct {
        logic [29:0] addr;
        logic [15:0] tag;
        logic        taken;
        int          avail;
    } entry_t;

    entry_t      sb[$];
    bit          pend = 1'b0;
    logic [29:0] pend_addr;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; the model decides acceptance and records captures.
    task automatic applyStimulus(input logic req, input logic [29:0] addr, input logic [15:0] tag,
                                 input logic taken, input logic ready, input logic flush);
        bit exp_full;
        entry_t e;
        @(posedge clk);
        #1;
        exp_full = (sb.size() + int'(pend)) >= DEPTH;
        checkOutput("full", 32'(bpq_full), 32'(exp_full));
        fetch_bp_req   = req;
        fetch_bp_addr  = addr;
        brpred_bptag   = tag;
        brpred_bptaken = taken;
        dec_bpq_ready  = ready;
        rob_flush      = flush;
        if (flush) begin
            sb.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                e.addr  = pend_addr;
                e.tag   = tag;
                e.taken = taken;
`ifdef BPQ_BYPASS_EN
                e.avail = cyc;
`else
                e.avail = cyc + 1;
`endif
                sb.push_back(e);
            end
            pend = req && !exp_full;
            if (pend) pend_addr = addr;
        end
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 30'($urandom), 16'($urandom), 1'($urandom), ready, 1'b0);
    endtask

    task automatic pulseReset(input int hold);
        @(posedge clk);
        #3;
        rst_n        = 1'b0;
        fetch_bp_req = 1'b0;
        rob_flush    = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(bpq_valid), 32'd0);
        checkOutput("rst_full", 32'(bpq_full), 32'd0);
        sb.delete();
        pend = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the head against the oldest predicted entry on every consume.
    always @(negedge clk) begin
        bit exp_valid;
        if (rst_n && !rob_flush) begin
            exp_valid = (sb.size() > 0) && (sb[0].avail <= cyc);
            checkOutput("valid", 32'(bpq_valid), 32'(exp_valid));
            if (bpq_valid && dec_bpq_ready && exp_valid) begin
                checkOutput("addr", 32'(bpq_addr), 32'(sb[0].addr));
                checkOutput("tag", 32'(bpq_bptag), 32'(sb[0].tag));
                checkOutput("taken", 32'(bpq_bptaken), 32'(sb[0].taken));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        fetch_bp_req   = 1'b0;
        fetch_bp_addr  = '0;
        brpred_bptag   = '0;
        brpred_bptaken = 1'b0;
        rob_flush      = 1'b0;
        dec_bpq_ready  = 1'b0;
        #2;
        checkOutput("reset_valid", 32'(bpq_valid), 32'd0);
        checkOutput("reset_full", 32'(bpq_full), 32'd0);
        #20;
        rst_n = 1'b1;

        applyStimulus(1'b1, 30'h400, 16'h8123, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);

        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 30'(16'h100 + i), 16'($urandom), 1'($urandom), 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(DEPTH + 3, 1'b1);

        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 30'(16'h200 + i), 16'(16'hA000 + i), 1'(i), 1'b1, 1'b0);
        idle(4, 1'b1);

        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 30'(16'h300 + i), 16'($urandom), 1'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, 30'h3FF, 16'h5555, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);

        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 30'(16'h400 + i), 16'($urandom), 1'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, 30'h4FF, 16'($urandom), 1'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b1, 30'h4FE, 16'($urandom), 1'($urandom), 1'b1, 1'b0);
        idle(DEPTH + 3, 1'b1);

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 30'(16'h500 + i), 16'($urandom), 1'($urandom), 1'(i), 1'b0);
        pulseReset(2);
        applyStimulus(1'b1, 30'h600, 16'h6006, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 30'($urandom), 16'($urandom), 1'($urandom),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
            if (i == 200) pulseReset(1);
        end

        idle(DEPTH + 4, 1'b1);
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
